sevenseg_scanner: RTL



---
 rtl/sevenseg_scanner.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sevenseg_scanner.sv
// Time-multiplexed seven-segment scanner: holds a hex value in a shadow register and
// walks it digit by digit through one shared decoder, with a blank gap between digits.
module sevenseg_scanner #(
    parameter int NUM_DIGITS = 8,
    parameter int DWELL      = 1024,
    parameter int BLANK_CYC  = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [4*NUM_DIGITS-1:0] in_data,
    output logic                    in_ready,
    input  logic                    lz_en,
    output logic [3:0]              nibble,
    output logic                    blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    localparam int CNT_MAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(NUM_DIGITS);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]      shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0][3:0]      pending_q, pending_d;
    logic                            pend_full_q, pend_full_d;
    logic                            in_ready_q, in_ready_d;
    logic [NUM_DIGITS-1:0]           an_q, an_d;
    logic [3:0]                      nibble_q, nibble_d;
    logic                            blank_q, blank_d;
    logic                            frame_done_q, frame_done_d;

    // hi_zero[i]: shadow nibbles i..NUM_DIGITS-1 are all zero
    logic [NUM_DIGITS-1:0] hi_zero;
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_hz
        assign hi_zero[i] = (shadow_q[NUM_DIGITS-1:i] == '0);
    end

    logic suppressed;
    assign suppressed = lz_en && (idx_q != '0) && hi_zero[idx_q];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        pend_full_d  = pend_full_q;
        an_d         = an_q;
        nibble_d     = nibble_q;
        blank_d      = blank_q;
        frame_done_d = 1'b0;

        // Transfer and frame-boundary copy are mutually exclusive on pend_full_q.
        if (in_valid && !pend_full_q) begin
            pending_d   = in_data;
            pend_full_d = 1'b1;
        end

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CW'(BLANK_CYC - 1)) begin
                    state_d     = ST_SHOW;
                    cnt_d       = '0;
                    an_d        = '1;
                    an_d[idx_q] = 1'b0;
                    blank_d     = suppressed;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (cnt_q == CW'(DWELL - 1)) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    an_d    = '1;
                    blank_d = 1'b1;
                    if (idx_q == IW'(NUM_DIGITS - 1)) begin
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                        if (pend_full_q) begin
                            shadow_d    = pending_q;
                            pend_full_d = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                    // Decoder input settles for the whole blank gap before lighting.
                    nibble_d = shadow_d[idx_d];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        in_ready_d = !pend_full_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            pending_q    <= '0;
            pend_full_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            an_q         <= '1;
            nibble_q     <= '0;
            blank_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_full_q  <= pend_full_d;
            in_ready_q   <= in_ready_d;
            an_q         <= an_d;
            nibble_q     <= nibble_d;
            blank_q      <= blank_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign an         = an_q;
    assign nibble     = nibble_q;
    assign blank      = blank_q;
    assign frame_done = frame_done_q;

endmodule
